// File: rtl/dmem_dma_if.sv
// Data-memory port between the block-transfer engine (master) and the 256 x 8 memory (slave).
// Data_out is the memory's combinational read data at Address.
interface dmem_dma_if;
    logic       MW;
    logic [7:0] Address;
    logic [7:0] Data_in;
    logic [7:0] Data_out;

    modport master (
        output MW,
        output Address,
        output Data_in,
        input  Data_out
    );

    modport slave (
        input  MW,
        input  Address,
        input  Data_in,
        output Data_out
    );
endinterface

// File: rtl/dmem_dma.sv
// Byte-wide block-transfer engine: ascending memory-to-memory copy or constant fill.
// All outputs are registered and updated together with the state they belong to.
module dmem_dma (
    input  logic       clk,
    input  logic       rst,
    input  logic       Start,
    input  logic       Mode,
    input  logic [7:0] Src,
    input  logic [7:0] Dst,
    input  logic [7:0] Len,
    input  logic [7:0] Fill,
    output logic       Busy,
    output logic       Done,
    output logic [7:0] Count,
    dmem_dma_if.master mem
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_t;

    state_t     state_q;
    logic       mode_q;
    logic [7:0] sptr_q;
    logic [7:0] dptr_q;
    logic [7:0] rem_q;
    logic [7:0] data_buf_q;
    logic [7:0] count_q;
    logic       busy_q;
    logic       done_q;
    logic       mw_q;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;

    assign Busy        = busy_q;
    assign Done        = done_q;
    assign Count       = count_q;
    assign mem.MW      = mw_q;
    assign mem.Address = addr_q;
    assign mem.Data_in = wdata_q;

    // Output registers are loaded with the values of the state being entered, so they
    // always read as a Moore decode of the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            mode_q     <= 1'b0;
            sptr_q     <= 8'h00;
            dptr_q     <= 8'h00;
            rem_q      <= 8'h00;
            data_buf_q <= 8'h00;
            count_q    <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mw_q       <= 1'b0;
            addr_q     <= 8'h00;
            wdata_q    <= 8'h00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (Start) begin
                        mode_q     <= Mode;
                        sptr_q     <= Src;
                        dptr_q     <= Dst;
                        rem_q      <= Len;
                        data_buf_q <= Mode ? Fill : 8'h00;
                        count_q    <= 8'h00;
                        if (Len == 8'h00) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else if (!Mode) begin
                            state_q <= StRd;
                            busy_q  <= 1'b1;
                            addr_q  <= Src;
                        end else begin
                            state_q <= StWr;
                            busy_q  <= 1'b1;
                            mw_q    <= 1'b1;
                            addr_q  <= Dst;
                            wdata_q <= Fill;
                        end
                    end
                end
                StRd: begin
                    data_buf_q <= mem.Data_out;
                    sptr_q     <= sptr_q + 8'd1;
                    state_q    <= StWr;
                    mw_q       <= 1'b1;
                    addr_q     <= dptr_q;
                    wdata_q    <= mem.Data_out;
                end
                StWr: begin
                    dptr_q  <= dptr_q + 8'd1;
                    rem_q   <= rem_q - 8'd1;
                    count_q <= count_q + 8'd1;
                    if (rem_q == 8'd1) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        mw_q    <= 1'b0;
                        addr_q  <= 8'h00;
                        wdata_q <= 8'h00;
                        done_q  <= 1'b1;
                    end else if (!mode_q) begin
                        state_q <= StRd;
                        mw_q    <= 1'b0;
                        addr_q  <= sptr_q;
                        wdata_q <= 8'h00;
                    end else begin
                        // Fill stays in WR; the write data register already holds the fill byte.
                        addr_q <= dptr_q + 8'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_dma.sv
// Bench for dmem_dma: directed test-plan jobs plus random jobs against a byte-level memory
// model computed from the copy/fill rules.
module tb_dmem_dma;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       Start = 1'b0;
    logic       Mode = 1'b0;
    logic [7:0] Src = 8'h00;
    logic [7:0] Dst = 8'h00;
    logic [7:0] Len = 8'h00;
    logic [7:0] Fill = 8'h00;
    logic       Busy;
    logic       Done;
    logic [7:0] Count;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem     [256];
    logic [7:0] exp_mem [256];

    dmem_dma_if bus ();

    dmem_dma dut (
        .clk   (clk),
        .rst   (rst),
        .Start (Start),
        .Mode  (Mode),
        .Src   (Src),
        .Dst   (Dst),
        .Len   (Len),
        .Fill  (Fill),
        .Busy  (Busy),
        .Done  (Done),
        .Count (Count),
        .mem   (bus)
    );

    always #5 clk = ~clk;

    assign bus.Data_out = mem[bus.Address];

    always @(posedge clk) begin
        if (bus.MW) mem[bus.Address] <= bus.Data_in;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_mem(input logic [7:0] a, input logic [7:0] v);
        mem[a]     <= v;
        exp_mem[a] = v;
    endtask

    // poke: cycle in which a second Start is raised (0 = none); rcyc: cycle whose ending
    // edge sees rst (0 = none).
    task automatic run_job(input string name, input logic m, input logic [7:0] s,
                           input logic [7:0] d, input logic [7:0] l, input logic [7:0] f,
                           input int poke, input int rcyc);
        logic [7:0] img [256];
        logic [7:0] wexp [$];
        logic [7:0] a;
        logic [7:0] v;
        int n_wr, busy_n, mw_n, done_n, done_cyc, seq_err, rd_i, wr_i, bad;
        int cnt_done, cnt_after, rst_busy, rst_cnt, rst_mw;
        bit fin;
        busy_n = 0; mw_n = 0; done_n = 0; done_cyc = 0; seq_err = 0; rd_i = 0; wr_i = 0;
        bad = 0; cnt_done = 0; cnt_after = 0; rst_busy = 0; rst_cnt = 0; rst_mw = 0; fin = 0;

        // Reference: bytes are transferred one at a time in ascending order.
        img  = exp_mem;
        n_wr = int'(l);
        if (rcyc != 0) n_wr = m ? rcyc : rcyc / 2;
        if (n_wr > int'(l)) n_wr = int'(l);
        for (int i = 0; i < n_wr; i++) begin
            a = s + 8'(i);
            v = m ? f : img[a];
            a = d + 8'(i);
            img[a] = v;
            wexp.push_back(v);
        end

        @(negedge clk);
        Mode = m; Src = s; Dst = d; Len = l; Fill = f; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        Mode = 1'($urandom); Src = 8'($urandom); Dst = 8'($urandom);
        Len = 8'($urandom); Fill = 8'($urandom);
        for (int c = 1; c <= 600 && !fin; c++) begin
            if (Busy) busy_n++;
            if (bus.MW) begin
                mw_n++;
                a = d + 8'(wr_i);
                if (wr_i >= wexp.size()) seq_err++;
                else if (bus.Address !== a || bus.Data_in !== wexp[wr_i]) seq_err++;
                wr_i++;
            end else if (Busy) begin
                a = s + 8'(rd_i);
                if (bus.Address !== a) seq_err++;
                rd_i++;
            end
            if (Done) begin
                done_n++;
                if (done_cyc == 0) begin
                    done_cyc = c;
                    cnt_done = int'(Count);
                end
            end
            if (rcyc != 0 && c == rcyc + 1) begin
                rst_busy = int'(Busy); rst_cnt = int'(Count); rst_mw = int'(bus.MW);
            end
            if (poke != 0 && c == poke) begin
                Start = 1'b1; Mode = ~m; Src = s + 8'h80; Dst = d + 8'h80; Len = 8'd7;
            end else if (poke != 0 && c == poke + 1) begin
                Start = 1'b0;
            end
            if (rcyc != 0 && c == rcyc) rst = 1'b1;
            else if (rcyc != 0 && c == rcyc + 1) rst = 1'b0;
            if (rcyc == 0 && done_cyc != 0 && c >= done_cyc + 2) begin
                cnt_after = int'(Count);
                fin = 1;
            end
            if (rcyc != 0 && c >= rcyc + 4) fin = 1;
            if (!fin) @(negedge clk);
        end
        check({name, " finished"}, 32'(fin), 32'd1);

        if (rcyc == 0) begin
            check({name, " done_cycle"}, done_cyc,
                  (l == 0) ? 1 : (m ? int'(l) + 1 : 2 * int'(l) + 1));
            check({name, " busy_cycles"}, busy_n, m ? int'(l) : 2 * int'(l));
            check({name, " done_pulses"}, done_n, 1);
            check({name, " count_at_done"}, cnt_done, int'(l));
            check({name, " count_held"}, cnt_after, int'(l));
        end else begin
            check({name, " done_pulses"}, done_n, 0);
            check({name, " busy_after_rst"}, rst_busy, 0);
            check({name, " count_after_rst"}, rst_cnt, 0);
            check({name, " mw_after_rst"}, rst_mw, 0);
        end
        check({name, " mw_cycles"}, mw_n, n_wr);
        check({name, " addr_data_seq"}, seq_err, 0);

        @(negedge clk);
        for (int i = 0; i < 256; i++) if (mem[i] !== img[i]) bad++;
        check({name, " mem_image"}, bad, 0);
        exp_mem = img;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) set_mem(8'(i), 8'($urandom));
        repeat (2) @(negedge clk);
        check("rst Busy", 32'(Busy), 32'd0);
        check("rst Done", 32'(Done), 32'd0);
        check("rst Count", 32'(Count), 32'd0);
        check("rst MW", 32'(bus.MW), 32'd0);
        check("rst Address", 32'(bus.Address), 32'd0);
        check("rst Data_in", 32'(bus.Data_in), 32'd0);
        rst = 1'b0;

        set_mem(8'h10, 8'hA1); set_mem(8'h11, 8'hB2);
        set_mem(8'h12, 8'hC3); set_mem(8'h13, 8'hD4);
        run_job("copy4", 1'b0, 8'h10, 8'h40, 8'd4, 8'h00, 0, 0);
        check("copy4 byte40", 32'(mem[8'h40]), 32'hA1);
        check("copy4 byte43", 32'(mem[8'h43]), 32'hD4);

        run_job("fill_wrap", 1'b1, 8'h00, 8'hFE, 8'd3, 8'h5A, 0, 0);
        check("fill_wrap byte00", 32'(mem[8'h00]), 32'h5A);

        run_job("zero_len", 1'b0, 8'h30, 8'h50, 8'd0, 8'h00, 0, 0);

        set_mem(8'h20, 8'h01); set_mem(8'h21, 8'h02);
        set_mem(8'h22, 8'h03); set_mem(8'h23, 8'h04);
        run_job("overlap", 1'b0, 8'h20, 8'h21, 8'd3, 8'h00, 0, 0);
        check("overlap byte23", 32'(mem[8'h23]), 32'h01);

        run_job("start_busy", 1'b0, 8'h60, 8'h70, 8'd4, 8'h00, 3, 0);

        run_job("rst_mid", 1'b0, 8'h80, 8'h90, 8'd4, 8'h00, 0, 4);

        run_job("copy_wrap", 1'b0, 8'hFD, 8'hB0, 8'd5, 8'h00, 0, 0);

        for (int k = 0; k < 6; k++) begin
            run_job("rand", 1'($urandom), 8'($urandom), 8'($urandom),
                    8'($urandom_range(0, 20)), 8'($urandom), 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_dma.md
# dmem_dma

Byte-wide block-transfer engine that acts as the initiator on the data-memory port. It drives `MW`, `Address` and `Data_in` and reads `Data_out`. It runs two job types from a single start pulse: a memory-to-memory copy, and a constant fill of a region. It sits beside the CPU datapath and owns the data-memory port while `Busy` is high; the top level muxes the port between CPU and engine on `Busy`.

## Interface
- No parameters; all widths are fixed at 8 bits to match the data-memory port (256 × 8).
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `Start` in 1: job request; sampled only in IDLE.
- `Mode` in 1: 0 = copy `Src`→`Dst`, 1 = fill `Dst` with `Fill`.
- `Src` in 8: copy source start address (ignored in fill).
- `Dst` in 8: destination start address.
- `Len` in 8: byte count, 0–255.
- `Fill` in 8: fill value (ignored in copy).
- `Busy` out 1: high while the job owns the memory port.
- `Done` out 1: one-cycle completion pulse.
- `Count` out 8: bytes written in the current or last job.
- `MW` out 1: memory write enable; memory writes at the rising edge while high.
- `Address` out 8: memory address.
- `Data_in` out 8: write data to memory.
- `Data_out` in 8: combinational read data from memory at `Address`.

## Operation
- States: IDLE, RD, WR, DONE. Outputs are Moore-decoded from state and internal registers.
- IDLE:
  - `Busy`=0, `MW`=0, `Address`=0, `Data_in`=0.
  - On `Start`=1, latch `Mode`, `Src`, `Dst`, `Len`, `Fill` into `sptr`, `dptr`, `rem`, `buf` (fill: `buf`=`Fill`), clear `Count`, then branch:
    - `Len`=0 → DONE.
    - copy → RD.
    - fill → WR.
- RD (copy only):
  - `Address`=`sptr`, `MW`=0.
  - At the edge: `buf`←`Data_out`, `sptr`←`sptr`+1 (mod 256), go to WR.
- WR:
  - `Address`=`dptr`, `Data_in`=`buf`, `MW`=1.
  - At the edge: `dptr`←`dptr`+1 (mod 256), `rem`←`rem`−1, `Count`←`Count`+1.
  - If `rem` was 1 → DONE; otherwise → RD (copy) or stay in WR (fill).
- DONE:
  - `Done`=1, `Busy`=0, `MW`=0; go to IDLE next cycle.
- `Busy`=1 exactly in RD and WR.
- Address arithmetic wraps modulo 256; a job crossing 0xFF continues at 0x00.
- Copy is strictly ascending, read-then-write per byte; no memmove semantics.
  - With overlap `Dst`=`Src`+k (0<k<`Len`), bytes already written are re-read.
  - The result is the periodic replication of the first k source bytes. This is required behaviour, not an error.
- `Start` outside IDLE (including DONE) is ignored; the latched job parameters do not change mid-job.
- Input changes on `Src`/`Dst`/`Len`/`Fill`/`Mode` after the start edge have no effect.
- `Count` holds its final value after DONE until the next accepted `Start` clears it.

## Timing
- Start accepted at edge E0. First RD/WR cycle is E0→E1.
- Copy of N≥1 bytes:
  - 2N busy cycles.
  - Byte i is read during cycle 2i+1 and written at the end of cycle 2i+2.
  - `Done` is high in cycle 2N+1; IDLE from cycle 2N+2.
- Fill of N≥1 bytes: N busy cycles, `Done` in cycle N+1.
- `Len`=0: DONE in cycle 1, `Busy` never rises, `MW` never rises, `Count`=0.
- Back-to-back jobs: earliest next accepted `Start` is at the edge ending DONE+1 (the first IDLE cycle).
- Reset:
  - `rst`=1 at an edge forces IDLE and clears `Busy`, `Done`, `Count`, `MW`, `Address`, `Data_in` and all internal registers.
  - `rst` has priority over `Start`.
  - Reset mid-job: if the cycle ending at the reset edge was WR, that byte is written (`MW` was high at the edge). No further write occurs.
  - `Count` reads 0 after reset, not the partial total.
- `Data_out` is consumed only in RD, in the same cycle it is addressed (combinational memory read, no wait state).

## Test plan
- Copy:
  - Stimulus: memory[0x10..0x13]=A1,B2,C3,D4; Start with Mode=0, Src=0x10, Dst=0x40, Len=4.
  - Response: memory[0x40..0x43]=A1,B2,C3,D4; `Busy` high 8 cycles; `Done` pulse in cycle 9; `Count`=4; memory[0x44] unchanged.
- Fill with wrap:
  - Stimulus: Mode=1, Dst=0xFE, Len=3, Fill=0x5A.
  - Response: memory[0xFE], [0xFF], [0x00]=5A; 3 busy cycles; `MW` high exactly 3 cycles; `Address` sequence FE, FF, 00.
- Zero length:
  - Stimulus: Len=0 in copy mode.
  - Response: `Done` in cycle 1; `Busy` and `MW` never assert; `Count`=0; memory unchanged.
- Overlap:
  - Stimulus: memory[0x20..0x23]=01,02,03,04; copy Src=0x20, Dst=0x21, Len=3.
  - Response: memory[0x21..0x23]=01,01,01.
- Start while busy:
  - Stimulus: Start a 4-byte copy; pulse Start with different Src/Dst in cycle 3.
  - Response: second request ignored; only the original destination is written; exactly one `Done`.
- Reset mid-copy:
  - Stimulus: assert `rst` at the edge ending cycle 4 of a 4-byte copy (cycle 4 is the WR of byte 1).
  - Response: bytes 0 and 1 written, bytes 2 and 3 not; next cycle `Busy`=0, `Count`=0, `MW`=0; no `Done` pulse.
